// File: rtl/dmux_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// dmux_rr_dispatcher
//
// Round-robin dispatcher for a 1-to-4, 4-bit demultiplexer datapath.
// A single producer delivers 4-bit words over a valid/ready handshake. Each
// accepted word goes into the one-entry holding register of the channel
// currently addressed by the round-robin pointer. Each channel (a, b, c, d)
// hands its word to an independent consumer over its own valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all valids and pointer)
//   en         dispatch enable; low blocks new accepts and freezes the pointer
//   in_data    input word
//   in_valid   producer has a word on in_data
//   in_ready   word is accepted this cycle (combinational)
//   a, b, c, d channel data; the held word while valid, otherwise 4'b0000
//   out_valid  per-channel valid, bit 0 = a ... bit 3 = d
//   out_ready  per-channel consumer ready, bit 0 = a ... bit 3 = d
//   sel        round-robin pointer (next target channel)
//
// Build option
//   DMUX_RR_SKIP_BUSY_EN  undefined: strict order, the target is always sel.
//                         defined:   the target is the first accepting channel
//                                    searching sel, sel+1, sel+2, sel+3.
// -----------------------------------------------------------------------------
module dmux_rr_dispatcher (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [1:0] sel
);

    // Holding registers carry no reset: their contents are never visible
    // unless the matching full bit is set, and the full bits do reset.
    logic [3:0] hold [4];
    logic [3:0] full;
    logic [1:0] ptr;

    logic [3:0] accepting;
    logic [3:0] consume;
    logic [3:0] write;
    logic [1:0] target;
    logic       target_ok;
    logic       accept;

    // Returns {found, channel}. A channel that is being drained this cycle
    // counts as accepting, so a full channel can be refilled without a bubble.
    function automatic logic [2:0] pick_target(input logic [1:0] start,
                                               input logic [3:0] acc);
`ifdef DMUX_RR_SKIP_BUSY_EN
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, start};
        // Walk from the farthest offset back to zero so the nearest hit wins.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (acc[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
`else
        return {acc[start], start};
`endif
    endfunction

    always_comb begin
        accepting           = ~full | out_ready;
        consume             = full & out_ready;
        {target_ok, target} = pick_target(ptr, accepting);
        // Holding off while reset is asserted keeps the producer from
        // believing a word was taken that the cleared state will never show.
        in_ready            = en & ~rst & target_ok;
        accept              = in_valid & in_ready;
        write               = accept ? (4'b0001 << target) : 4'b0000;
    end

    // Control state: channel occupancy and the round-robin pointer.
    // A write wins over a consume on the same channel so the valid stays up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 4'b0000;
            ptr  <= 2'b00;
        end else begin
            full <= (full & ~consume) | write;
            if (accept) begin
                ptr <= target + 2'd1;
            end
        end
    end

    // Datapath: only the addressed holding register loads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write[i]) begin
                hold[i] <= in_data;
            end
        end
    end

    assign a         = full[0] ? hold[0] : 4'b0000;
    assign b         = full[1] ? hold[1] : 4'b0000;
    assign c         = full[2] ? hold[2] : 4'b0000;
    assign d         = full[3] ? hold[3] : 4'b0000;
    assign out_valid = full;
    assign sel       = ptr;

endmodule
